adder_arbiter: RTL

- Shares one `adder` instance between two independent requesters, serialising their operations.
- Each requester presents an operand pair (a, b) on a stb/ack channel and receives its sum back on its own stb/ack result channel.
- Grants alternate round-robin, so neither requester starves.
- Sits between requester sources (file readers, compute blocks) and a single `adder`; pins onto the adder's input_a/input_b/output_z ports.

---
 rtl/adder_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder between two requesters, serving one
// operation at a time with round-robin grants. Operands and results are
// passed through untouched; every output comes straight from a flop.
module adder_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_stb,
  output logic             req0_ack,
  output logic [WIDTH-1:0] res0_z,
  output logic             res0_z_stb,
  input  logic             res0_z_ack,
  // requester 1
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_stb,
  output logic             req1_ack,
  output logic [WIDTH-1:0] res1_z,
  output logic             res1_z_stb,
  input  logic             res1_z_ack,
  // shared adder
  output logic [WIDTH-1:0] adder_a,
  output logic             adder_a_stb,
  input  logic             adder_a_ack,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_b_stb,
  input  logic             adder_b_ack,
  input  logic [WIDTH-1:0] adder_z,
  input  logic             adder_z_stb,
  output logic             adder_z_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    SEND    = 3'd2,
    WAIT_Z  = 3'd3,
    DELIVER = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;
  logic             req0_ack_q, req0_ack_d;
  logic             req1_ack_q, req1_ack_d;
  logic [WIDTH-1:0] adder_a_q, adder_a_d;
  logic [WIDTH-1:0] adder_b_q, adder_b_d;
  logic             adder_a_stb_q, adder_a_stb_d;
  logic             adder_b_stb_q, adder_b_stb_d;
  logic             adder_z_ack_q, adder_z_ack_d;
  logic [WIDTH-1:0] res0_z_q, res0_z_d;
  logic [WIDTH-1:0] res1_z_q, res1_z_d;
  logic             res0_z_stb_q, res0_z_stb_d;
  logic             res1_z_stb_q, res1_z_stb_d;

  // Handshake events and arbitration decode shared by both comb processes
  logic pick_c;
  logic any_req_c;
  logic req_xfer_c;
  logic a_xfer_c, b_xfer_c;
  logic a_fin_c, b_fin_c;
  logic z_xfer_c;
  logic res_xfer_c;

  // Decode the handshakes of the currently granted requester and the adder
  always_comb begin
    any_req_c  = req0_stb | req1_stb;
    // Both pending: take the one not served last; otherwise whoever asks
    pick_c     = (req0_stb & req1_stb) ? ~last_grant_q : req1_stb;
    req_xfer_c = grant_q ? (req1_stb & req1_ack_q) : (req0_stb & req0_ack_q);
    a_xfer_c   = adder_a_stb_q & adder_a_ack;
    b_xfer_c   = adder_b_stb_q & adder_b_ack;
    a_fin_c    = a_done_q | a_xfer_c;
    b_fin_c    = b_done_q | b_xfer_c;
    z_xfer_c   = adder_z_stb & adder_z_ack_q;
    res_xfer_c = grant_q ? (res1_z_stb_q & res1_z_ack) : (res0_z_stb_q & res0_z_ack);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req_c)           state_d = ACCEPT;
      ACCEPT:  if (req_xfer_c)          state_d = SEND;
      SEND:    if (a_fin_c && b_fin_c)  state_d = WAIT_Z;
      WAIT_Z:  if (z_xfer_c)            state_d = DELIVER;
      DELIVER: if (res_xfer_c)          state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every register holds unless changed
  always_comb begin
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    a_done_d      = a_done_q;
    b_done_d      = b_done_q;
    req0_ack_d    = req0_ack_q;
    req1_ack_d    = req1_ack_q;
    adder_a_d     = adder_a_q;
    adder_b_d     = adder_b_q;
    adder_a_stb_d = adder_a_stb_q;
    adder_b_stb_d = adder_b_stb_q;
    adder_z_ack_d = adder_z_ack_q;
    res0_z_d      = res0_z_q;
    res1_z_d      = res1_z_q;
    res0_z_stb_d  = res0_z_stb_q;
    res1_z_stb_d  = res1_z_stb_q;
    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          grant_d = pick_c;
          if (pick_c) req1_ack_d = 1'b1;
          else        req0_ack_d = 1'b1;
        end
      end
      ACCEPT: begin
        if (req_xfer_c) begin
          adder_a_d     = grant_q ? req1_a : req0_a;
          adder_b_d     = grant_q ? req1_b : req0_b;
          req0_ack_d    = 1'b0;
          req1_ack_d    = 1'b0;
          adder_a_stb_d = 1'b1;
          adder_b_stb_d = 1'b1;
          a_done_d      = 1'b0;
          b_done_d      = 1'b0;
        end
      end
      SEND: begin
        // Operands complete independently, in any order or together
        if (a_xfer_c) begin
          adder_a_stb_d = 1'b0;
          a_done_d      = 1'b1;
        end
        if (b_xfer_c) begin
          adder_b_stb_d = 1'b0;
          b_done_d      = 1'b1;
        end
        if (a_fin_c && b_fin_c) adder_z_ack_d = 1'b1;
      end
      WAIT_Z: begin
        if (z_xfer_c) begin
          adder_z_ack_d = 1'b0;
          if (grant_q) begin
            res1_z_d     = adder_z;
            res1_z_stb_d = 1'b1;
          end else begin
            res0_z_d     = adder_z;
            res0_z_stb_d = 1'b1;
          end
        end
      end
      DELIVER: begin
        if (res_xfer_c) begin
          res0_z_stb_d = 1'b0;
          res1_z_stb_d = 1'b0;
          last_grant_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; last_grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      req0_ack_q    <= 1'b0;
      req1_ack_q    <= 1'b0;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      adder_a_stb_q <= 1'b0;
      adder_b_stb_q <= 1'b0;
      adder_z_ack_q <= 1'b0;
      res0_z_q      <= '0;
      res1_z_q      <= '0;
      res0_z_stb_q  <= 1'b0;
      res1_z_stb_q  <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      req0_ack_q    <= req0_ack_d;
      req1_ack_q    <= req1_ack_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      adder_a_stb_q <= adder_a_stb_d;
      adder_b_stb_q <= adder_b_stb_d;
      adder_z_ack_q <= adder_z_ack_d;
      res0_z_q      <= res0_z_d;
      res1_z_q      <= res1_z_d;
      res0_z_stb_q  <= res0_z_stb_d;
      res1_z_stb_q  <= res1_z_stb_d;
    end
  end

  assign req0_ack    = req0_ack_q;
  assign req1_ack    = req1_ack_q;
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign adder_a_stb = adder_a_stb_q;
  assign adder_b_stb = adder_b_stb_q;
  assign adder_z_ack = adder_z_ack_q;
  assign res0_z      = res0_z_q;
  assign res1_z      = res1_z_q;
  assign res0_z_stb  = res0_z_stb_q;
  assign res1_z_stb  = res1_z_stb_q;

endmodule
